// File: rtl/acc_v3.sv
// acc_v3: per-lane multi-pass psum accumulator with round/saturate output.
// Optional ReLU before rounding is built when ACC_V3_RELU_EN is defined.
module acc_v3 #(
  parameter int PE_SIZE    = 14,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start_i,
  input  logic [CNT_WIDTH-1:0]          cfg_pass_num_i,
  input  logic [$clog2(DEPTH+1)-1:0]    cfg_col_num_i,
  input  logic [$clog2(PSUM_WIDTH)-1:0] cfg_shift_i,
`ifdef ACC_V3_RELU_EN
  input  logic                          cfg_relu_i,
`endif
  input  logic [PE_SIZE-1:0]            psum_en_row_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_o,
  output logic [PE_SIZE-1:0]            ofmap_en_row_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          sat_o,
  output logic                          err_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(PSUM_WIDTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = PSUM_WIDTH + 1;
  localparam logic signed [EW-1:0] QMAX =
    EW'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [EW-1:0] QMIN = -QMAX - 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_WIDTH-1:0] r_k;
  logic [CW-1:0]        r_n;
  logic [SW-1:0]        r_shift;
  logic                 r_relu;
  logic                 r_done;
  logic                 r_sat;
  logic                 r_err;

  logic                 w_run;
  logic                 w_idle;
  logic                 w_cfg_ok;
  logic                 w_start;
  logic                 w_bad_start;
  logic                 w_all_done;
  logic [CNT_WIDTH-1:0] w_k_last;
  logic [CW-1:0]        w_n_last;
  logic [PE_SIZE-1:0]   w_ldone;
  logic [PE_SIZE-1:0]   w_fin;
  logic [PE_SIZE-1:0]   w_clip;
  logic [PE_SIZE-1:0]   w_lerr;

  assign w_run    = (r_state == S_RUN);
  assign w_idle   = (r_state == S_IDLE);
  assign w_cfg_ok = (cfg_pass_num_i != '0) &&
                    (cfg_col_num_i != '0) &&
                    (cfg_col_num_i <= CW'(DEPTH));
  assign w_start     = w_idle & cfg_start_i & w_cfg_ok;
  assign w_bad_start = w_idle & cfg_start_i & ~w_cfg_ok;
  assign w_k_last    = r_k - 1'b1;
  assign w_n_last    = r_n - 1'b1;
  assign w_all_done  = &(w_ldone | w_fin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start)    w_state_nxt = S_RUN;
      S_RUN:  if (w_all_done) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_n     <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_run & w_all_done;
      if (w_start) begin
        r_k     <= cfg_pass_num_i;
        r_n     <= cfg_col_num_i;
        r_shift <= cfg_shift_i;
`ifdef ACC_V3_RELU_EN
        r_relu  <= cfg_relu_i;
`else
        r_relu  <= 1'b0;
`endif
        r_sat   <= 1'b0;
        r_err   <= 1'b0;
      end else if (|w_clip) begin
        r_sat <= 1'b1;
      end
      // error sources win over the clear of an accepted start
      if (w_bad_start | (w_idle & |psum_en_row_i) | |w_lerr)
        r_err <= 1'b1;
    end
  end

  assign busy_o = w_run;
  assign done_o = r_done;
  assign sat_o  = r_sat;
  assign err_o  = r_err;

  for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
    logic [PSUM_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_ptr;
    logic [CNT_WIDTH-1:0]  r_pass;
    logic                  r_ldone;
    logic                  r_oen;
    logic [DATA_WIDTH-1:0] r_odata;

    logic                  w_act;
    logic                  w_lastp;
    logic                  w_laste;
    logic [PSUM_WIDTH-1:0] w_psum;
    logic [PSUM_WIDTH-1:0] w_sum;
    logic signed [EW-1:0]  w_ext;
    logic signed [EW-1:0]  w_rnd;
    logic signed [EW-1:0]  w_shr;
    logic [DATA_WIDTH-1:0] w_q;
    logic                  w_sat;

    assign w_psum  = psum_row_i[PSUM_WIDTH*j +: PSUM_WIDTH];
    assign w_act   = w_run & psum_en_row_i[j] & ~r_ldone;
    assign w_lastp = (r_pass == w_k_last);
    assign w_laste = (CW'(r_ptr) == w_n_last);
    assign w_sum   = (r_pass == '0) ? w_psum
                                    : r_mem[r_ptr] + w_psum;

    always_comb begin
      w_ext = {w_sum[PSUM_WIDTH-1], w_sum};
      w_rnd = '0;
      w_sat = 1'b0;
      if (r_relu && w_ext < 0) w_ext = '0;
      if (r_shift != '0)
        w_rnd = EW'(1) << (r_shift - 1'b1);
      w_shr = (w_ext + w_rnd) >>> r_shift;
      w_q   = w_shr[DATA_WIDTH-1:0];
      if (w_shr > QMAX) begin
        w_q   = QMAX[DATA_WIDTH-1:0];
        w_sat = 1'b1;
      end else if (w_shr < QMIN) begin
        w_q   = QMIN[DATA_WIDTH-1:0];
        w_sat = 1'b1;
      end
    end

    // no reset: pass 0 always overwrites before any read
    always_ff @(posedge clk) begin
      if (w_act && !w_lastp) r_mem[r_ptr] <= w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ptr   <= '0;
        r_pass  <= '0;
        r_ldone <= 1'b0;
        r_oen   <= 1'b0;
        r_odata <= '0;
      end else begin
        r_oen <= w_act & w_lastp;
        if (w_act && w_lastp) r_odata <= w_q;
        if (w_start) begin
          r_ptr   <= '0;
          r_pass  <= '0;
          r_ldone <= 1'b0;
        end else if (w_act) begin
          if (w_laste) begin
            r_ptr  <= '0;
            r_pass <= r_pass + 1'b1;
            if (w_lastp) r_ldone <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
      end
    end

    assign w_ldone[j] = r_ldone;
    assign w_fin[j]   = w_act & w_lastp & w_laste;
    assign w_clip[j]  = w_act & w_lastp & w_sat;
    assign w_lerr[j]  = w_run & psum_en_row_i[j] & r_ldone;
    assign ofmap_en_row_o[j] = r_oen;
    assign ofmap_row_o[DATA_WIDTH*j +: DATA_WIDTH] = r_odata;
  end

endmodule
